// File: rtl/gate_array_pkg.sv
// Shared definitions for the gate array: op encoding and op legality check.
// Imported by gate_reduce and gate_array_sync.
package gate_array_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'b000;
  localparam logic [OP_W-1:0] OP_NAND = 3'b001;
  localparam logic [OP_W-1:0] OP_OR   = 3'b010;
  localparam logic [OP_W-1:0] OP_NOR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b100;
  localparam logic [OP_W-1:0] OP_XNOR = 3'b101;

  // Codes above OP_XNOR are reserved and flagged as illegal.
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op <= OP_XNOR);
  endfunction

endpackage

// File: rtl/gate_reduce.sv
// Combinational INPUTS-wide reduction gate with a run-time selectable function.
// Any illegal op code yields 0.
module gate_reduce
  import gate_array_pkg::*;
#(
  parameter int INPUTS = 3
) (
  input  logic [OP_W-1:0]   op,
  input  logic [INPUTS-1:0] a,
  output logic              r
);

  always_comb begin
    r = 1'b0;
    case (op)
      OP_AND:  r = &a;
      OP_NAND: r = ~&a;
      OP_OR:   r = |a;
      OP_NOR:  r = ~|a;
      OP_XOR:  r = ^a;
      OP_XNOR: r = ~^a;
      default: r = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_array_sync.sv
// CHANNELS parallel gates followed by a LATENCY-stage pipeline.
// The final stage doubles as the output register and the last-valid-y history.
module gate_array_sync
  import gate_array_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int INPUTS   = 3,
  parameter int LATENCY  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [OP_W-1:0]              op,
  input  logic [CHANNELS*INPUTS-1:0]   in_bus,
  input  logic                         in_valid,
  input  logic [CHANNELS-1:0]          chan_en,
  input  logic                         hold,
  output logic [CHANNELS-1:0]          y,
  output logic                         y_valid,
  output logic [CHANNELS-1:0]          y_changed,
  output logic                         op_err
);

  logic [CHANNELS-1:0] gate_raw;
  logic [CHANNELS-1:0] gate_res;
  logic [CHANNELS-1:0] fin_d;
  logic                fin_v;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    gate_reduce #(.INPUTS(INPUTS)) u_gate (
      .op (op),
      .a  (in_bus[c*INPUTS +: INPUTS]),
      .r  (gate_raw[c])
    );
  end

  assign gate_res = gate_raw & chan_en;

  // Stages 0..LATENCY-2 carry data and valid; the output register is the last stage.
  if (LATENCY == 1) begin : g_lat1
    assign fin_d = gate_res;
    assign fin_v = in_valid;
  end else begin : g_pipe
    logic [LATENCY-2:0][CHANNELS-1:0] pipe_d;
    logic [LATENCY-2:0]               pipe_v;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        pipe_d <= '0;
        pipe_v <= '0;
      end else if (!hold) begin
        pipe_d[0] <= gate_res;
        pipe_v[0] <= in_valid;
        for (int i = 1; i < LATENCY - 1; i++) begin
          pipe_d[i] <= pipe_d[i-1];
          pipe_v[i] <= pipe_v[i-1];
        end
      end
    end

    assign fin_d = pipe_d[LATENCY-2];
    assign fin_v = pipe_v[LATENCY-2];
  end

  // Bubbles leave y at the last valid value, so y itself is the change-detect reference.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y         <= '0;
      y_valid   <= 1'b0;
      y_changed <= '0;
      op_err    <= 1'b0;
    end else if (hold) begin
      y_changed <= '0;
    end else begin
      y_valid <= fin_v;
      if (fin_v) begin
        y         <= fin_d;
        y_changed <= fin_d ^ y;
      end else begin
        y_changed <= '0;
      end
      if (in_valid && !op_legal(op)) begin
        op_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gate_array_sync.sv
// Directed bench for gate_array_sync: three builds (LATENCY 2, 1, 8) share one stimulus
// stream; a scoreboard with per-build due-edge indices checks values and exact timing.
module tb_gate_array_sync;
  import gate_array_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] op = 3'b000;
  logic [8:0] in_bus = '0;
  logic       in_valid = 1'b0;
  logic [2:0] chan_en = '0;
  logic       hold = 1'b0;

  logic [2:0] y_a  [3];
  logic [2:0] yc_a [3];
  logic       yv_a [3];
  logic       err_a[3];

  always #5 clk = ~clk;

  gate_array_sync #(.CHANNELS(3), .INPUTS(3), .LATENCY(2)) dut_l2 (
    .clk(clk), .rst_n(rst_n), .op(op), .in_bus(in_bus), .in_valid(in_valid),
    .chan_en(chan_en), .hold(hold), .y(y_a[0]), .y_valid(yv_a[0]),
    .y_changed(yc_a[0]), .op_err(err_a[0]));

  gate_array_sync #(.CHANNELS(3), .INPUTS(3), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .op(op), .in_bus(in_bus), .in_valid(in_valid),
    .chan_en(chan_en), .hold(hold), .y(y_a[1]), .y_valid(yv_a[1]),
    .y_changed(yc_a[1]), .op_err(err_a[1]));

  gate_array_sync #(.CHANNELS(3), .INPUTS(3), .LATENCY(8)) dut_l8 (
    .clk(clk), .rst_n(rst_n), .op(op), .in_bus(in_bus), .in_valid(in_valid),
    .chan_en(chan_en), .hold(hold), .y(y_a[2]), .y_valid(yv_a[2]),
    .y_changed(yc_a[2]), .op_err(err_a[2]));

  typedef struct {
    logic [2:0] y;
    int         due;
  } exp_t;

  exp_t sb [3][$];
  int   adv = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic hold_s = 1'b0;
  logic in_reset = 1'b1;
  logic [2:0] last_y [3] = '{default: '0};
  logic       exp_v  [3] = '{default: 1'b0};

  function automatic int lat_of(input int i);
    case (i)
      0:       return 2;
      1:       return 1;
      default: return 8;
    endcase
  endfunction

  function automatic logic [2:0] model(input logic [2:0] o, input logic [8:0] b,
                                       input logic [2:0] en);
    logic [2:0] r;
    logic [2:0] bits;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      bits = b[c*3 +: 3];
      case (o)
        3'd0:    r[c] = bits == 3'b111;
        3'd1:    r[c] = bits != 3'b111;
        3'd2:    r[c] = bits != 3'b000;
        3'd3:    r[c] = bits == 3'b000;
        3'd4:    r[c] = bits[0] ^ bits[1] ^ bits[2];
        3'd5:    r[c] = ~(bits[0] ^ bits[1] ^ bits[2]);
        default: r[c] = 1'b0;
      endcase
      r[c] = r[c] & en[c];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Edge bookkeeping: advancing edges index the scoreboard; reset flushes it.
  always @(posedge clk) begin
    hold_s   = hold;
    in_reset = !rst_n;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) sb[i].delete();
    end else if (!hold) begin
      adv++;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    logic due_now;
    for (int i = 0; i < 3; i++) begin
      if (in_reset) begin
        chk($sformatf("l%0d_rst_yv", lat_of(i)), yv_a[i], 1'b0);
        chk($sformatf("l%0d_rst_yc", lat_of(i)), yc_a[i], 3'b000);
        last_y[i] = '0;
        exp_v[i]  = 1'b0;
      end else if (hold_s) begin
        chk($sformatf("l%0d_hold_y", lat_of(i)), y_a[i], last_y[i]);
        chk($sformatf("l%0d_hold_yv", lat_of(i)), yv_a[i], exp_v[i]);
        chk($sformatf("l%0d_hold_yc", lat_of(i)), yc_a[i], 3'b000);
      end else begin
        due_now = (sb[i].size() > 0) && (sb[i][0].due == adv);
        chk($sformatf("l%0d_yv", lat_of(i)), yv_a[i], due_now);
        exp_v[i] = due_now;
        if (due_now) begin
          e = sb[i].pop_front();
          chk($sformatf("l%0d_y", lat_of(i)), y_a[i], e.y);
          chk($sformatf("l%0d_yc", lat_of(i)), yc_a[i], e.y ^ last_y[i]);
          last_y[i] = e.y;
        end else begin
          chk($sformatf("l%0d_idle_y", lat_of(i)), y_a[i], last_y[i]);
          chk($sformatf("l%0d_idle_yc", lat_of(i)), yc_a[i], 3'b000);
        end
      end
    end
  end

  task automatic step(input logic r, input logic [2:0] o, input logic [8:0] b,
                      input logic v, input logic [2:0] en, input logic h);
    @(posedge clk);
    #1;
    rst_n = r; op = o; in_bus = b; in_valid = v; chan_en = en; hold = h;
    if (r && v && !h) begin
      for (int i = 0; i < 3; i++)
        sb[i].push_back('{y: model(o, b, en), due: adv + lat_of(i)});
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 3'd0, 9'h000, 1'b0, 3'b111, 1'b0);
  endtask

  task automatic chk_flags(input string tag, input logic err_exp);
    for (int i = 0; i < 3; i++)
      chk($sformatf("l%0d_%s", lat_of(i), tag), err_a[i], err_exp);
  endtask

  initial begin
    // Reset held two edges with in_valid and an illegal op present.
    step(1'b0, 3'b111, 9'h1ff, 1'b1, 3'b111, 1'b0);
    step(1'b0, 3'b111, 9'h1ff, 1'b1, 3'b111, 1'b0);
    step(1'b1, 3'b000, 9'h000, 1'b0, 3'b111, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("l%0d_reset_y", lat_of(i)), y_a[i], 3'b000);
      chk($sformatf("l%0d_reset_yv", lat_of(i)), yv_a[i], 1'b0);
      chk($sformatf("l%0d_reset_yc", lat_of(i)), yc_a[i], 3'b000);
    end
    chk_flags("reset_op_err", 1'b0);

    // Single AND sample: expected y=101.
    step(1'b1, OP_AND, 9'b111_011_111, 1'b1, 3'b111, 1'b0);
    idle(10);

    // Op sweep on channel 0 = 110, back to back.
    for (int k = 0; k < 6; k++) step(1'b1, 3'(k), 9'b000_000_110, 1'b1, 3'b111, 1'b0);
    idle(10);

    // Two samples in flight, then hold for three cycles.
    step(1'b1, OP_OR,  9'b001_000_100, 1'b1, 3'b111, 1'b0);
    step(1'b1, OP_XOR, 9'b011_111_001, 1'b1, 3'b111, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, OP_NOR, 9'h000, 1'b1, 3'b111, 1'b1);
    idle(10);

    // Channel enable masking, then an illegal op.
    step(1'b1, OP_NAND, 9'b000_000_000, 1'b1, 3'b010, 1'b0);
    step(1'b1, 3'b111,  9'h1ff,         1'b1, 3'b111, 1'b0);
    step(1'b1, OP_XNOR, 9'b110_101_000, 1'b1, 3'b111, 1'b0);
    idle(10);
    chk_flags("sticky_op_err", 1'b1);

    // Random back-to-back traffic.
    for (int k = 0; k < 24; k++)
      step(1'b1, 3'($urandom_range(0, 5)), 9'($urandom), 1'($urandom_range(0, 1)),
           3'($urandom), 1'b0);
    idle(10);

    // Reset mid-flight: flushed samples must never surface.
    step(1'b1, OP_OR,  9'h1ff, 1'b1, 3'b111, 1'b0);
    step(1'b1, OP_AND, 9'h1ff, 1'b1, 3'b111, 1'b0);
    step(1'b1, OP_OR,  9'h0f0, 1'b1, 3'b111, 1'b0);
    step(1'b0, OP_OR,  9'h1ff, 1'b1, 3'b111, 1'b0);
    idle(12);
    chk_flags("post_reset_op_err", 1'b0);

    for (int i = 0; i < 3; i++)
      chk($sformatf("l%0d_drained", lat_of(i)), 32'(sb[i].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
